// File: rtl/multiplier_32bit_seq.sv
// rtl/multiplier_32bit_seq.sv - sequential 32x32->64 unsigned shift-and-add multiplier
//
// Purpose:
//   Multiplies two unsigned 32-bit operands in 32 iterations.
//   One 32-bit adder is reused on every iteration to accumulate the partial products.
//   A start/busy/done handshake lets the multi-cycle control unit stall on the result.
//
// Ports (multiplier_32bit_seq):
//   i_clk      rising-edge clock
//   i_reset    asynchronous, active-high reset
//   i_start    request a multiply; sampled only while idle
//   i_a        multiplicand, sampled with i_start
//   i_b        multiplier, sampled with i_start
//   o_product  result register; holds the last completed product
//   o_busy     high while iterating
//   o_done     one-cycle pulse in the cycle o_product is updated
//
// Ports (FullAdder_32Bit):
//   i_a, i_b   addends
//   i_cin      carry in
//   o_sum      32-bit sum
//   o_cout     carry out

module FullAdder_32Bit (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {32'd0, i_cin};

endmodule

module multiplier_32bit_seq (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_product,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_mcand;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [5:0]  r_count;
  logic [63:0] r_product;
  logic        r_busy;
  logic        r_done;

  logic [31:0] w_addend;
  logic [31:0] w_sum;
  logic        w_cout;
  logic [63:0] w_shifted;

  // The partial product is added only when the current multiplier bit is set.
  assign w_addend = r_lo[0] ? r_mcand : 32'd0;

  FullAdder_32Bit u_adder (
    .i_a    (r_hi),
    .i_b    (w_addend),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // The carry-out becomes the new top bit.
  // The consumed multiplier bit lo[0] falls off the bottom.
  assign w_shifted = {w_cout, w_sum, r_lo[31:1]};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_mcand   <= 32'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_count   <= 6'd0;
      r_product <= 64'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_mcand <= i_a;
            r_hi    <= 32'd0;
            r_lo    <= i_b;
            r_count <= 6'd0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          {r_hi, r_lo} <= w_shifted;
          r_count      <= r_count + 6'd1;
          if (r_count == 6'd31) begin
            r_product <= w_shifted;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_product = r_product;
  assign o_busy    = r_busy;
  assign o_done    = r_done;

endmodule

// File: tb/tb_multiplier_32bit_seq.sv
// tb/tb_multiplier_32bit_seq.sv - directed and random bench for multiplier_32bit_seq

module tb_multiplier_32bit_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] product;
  logic        busy;
  logic        done;

  int n_cmp;
  int n_err;

  multiplier_32bit_seq dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_start   (start),
    .i_a       (a),
    .i_b       (b),
    .o_product (product),
    .o_busy    (busy),
    .o_done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h, want 0x%016h", tag, obs, exp);
    end
  endtask

  // Runs one multiply from an idle DUT.
  // It scrambles a/b right after the accepting edge.
  // Samples are taken on falling edges; sample k is the cycle after edge Ek.
  task automatic do_mul(input string tag, input logic [31:0] opa, input logic [31:0] opb,
                        input logic [63:0] exp);
    int          busy_cnt;
    int          done_cnt;
    int          done_at;
    int          k;
    logic [63:0] prev;
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    @(negedge clk);
    prev  = product;
    start = 1'b1;
    a     = opa;
    b     = opb;
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    k     = 1;
    while (done_cnt == 0 && k <= 40) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_at = k;
      end
      check({tag, " excl"}, {63'd0, busy & done}, 64'd0);
      if (!done) check({tag, " stable"}, product, prev);
      k++;
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd32);
    check({tag, " done_at"}, 64'(done_at), 64'd33);
    check({tag, " product"}, product, exp);
    check({tag, " done_pulse"}, {63'd0, done}, 64'd0);
    check({tag, " idle"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin : main
    int          done_cnt;
    int          busy_seen;
    int          last_done;
    logic [31:0] ra;
    logic [31:0] rb;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    start = 1'b0;
    a     = 32'd0;
    b     = 32'd0;
    repeat (3) @(negedge clk);
    check("rst product", product, 64'd0);
    check("rst busy", {63'd0, busy}, 64'd0);
    check("rst done", {63'd0, done}, 64'd0);
    reset = 1'b0;

    // A reset asserted in the middle of a run aborts it without a done pulse.
    @(negedge clk);
    start = 1'b1;
    a     = 32'd7;
    b     = 32'd9;
    @(negedge clk);
    start = 1'b0;
    check("abort busy_before", {63'd0, busy}, 64'd1);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort busy_async", {63'd0, busy}, 64'd0);
    @(negedge clk);
    reset     = 1'b0;
    done_cnt  = 0;
    busy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (busy) busy_seen++;
    end
    check("abort done_cnt", 64'(done_cnt), 64'd0);
    check("abort busy_cnt", 64'(busy_seen), 64'd0);
    check("abort product", product, 64'd0);

    do_mul("basic", 32'd3, 32'd5, 64'd15);
    do_mul("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    do_mul("zero", 32'd0, 32'hDEAD_BEEF, 64'd0);
    do_mul("ident", 32'h1234_5678, 32'd1, 64'h0000_0000_1234_5678);
    do_mul("pow2", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    do_mul("mixed", 32'h0001_0000, 32'h0000_FFFF, 64'h0000_0000_FFFF_0000);

    // Holding start continuously must give one multiply per 34 cycles.
    @(negedge clk);
    start     = 1'b1;
    a         = 32'd2;
    b         = 32'd3;
    done_cnt  = 0;
    last_done = -1;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      if (done) begin
        check("hold product", product, 64'd6);
        if (last_done < 0) check("hold first", 64'(k), 64'd33);
        else check("hold spacing", 64'(k - last_done), 64'd34);
        last_done = k;
        done_cnt++;
      end
      check("hold excl", {63'd0, busy & done}, 64'd0);
    end
    check("hold done_cnt", 64'(done_cnt), 64'd3);
    start = 1'b0;
    repeat (40) @(negedge clk);
    check("hold idle", {63'd0, busy}, 64'd0);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 1) ra = ra >> (i % 32);
      if (i % 4 == 2) rb = rb >> (i % 32);
      do_mul("rand", ra, rb, 64'(ra) * 64'(rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
